lbp: RTL and testbench
======================

# lbp

Local Binary Pattern engine for a 128×128 8-bit grayscale image. It reads gray pixels from an external image memory through a request/address port. For each interior pixel it computes the 8-bit LBP code from its 3×3 neighbourhood. It writes each code to an external result memory through an address/valid port, then raises `finish`.

## Interface
- No parameters; the image is fixed at 128×128 with 14-bit row-major addresses (`addr = y*128 + x`).
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `gray_ready`  in  1  image memory available; processing may start once high.
- `gray_req`  out  1  read request for pixel at `gray_addr`.
- `gray_addr`  out  14  read address.
- `gray_data`  in  8  pixel value returned for the address requested in the previous cycle.
- `lbp_valid`  out  1  write strobe; result memory captures `lbp_data` at `lbp_addr`.
- `lbp_addr`  out  14  write address (centre pixel address).
- `lbp_data`  out  8  LBP code.
- `finish`  out  1  whole image done; sticky.

## Operation
- Neighbour bit weights relative to centre gc at (y,x):
  - (y-1,x-1) = 1, (y-1,x) = 2, (y-1,x+1) = 4
  - (y,x-1) = 8, (y,x+1) = 16
  - (y+1,x-1) = 32, (y+1,x) = 64, (y+1,x+1) = 128
- Bit is 1 when neighbour ≥ gc (unsigned compare, equality gives 1); `lbp_data` is the sum of set weights.
- Only interior pixels are processed: y = 1..126, x = 1..126. That is 15876 writes, in raster order.
- Border pixels (row 0/127, column 0/127) are never written; the result memory is pre-cleared to 0.
- Datapath: 3×3 window registers, shifted left by one column per centre.
- FSM states: IDLE → LOAD → READ → WRITE → (READ | LOAD | DONE).
  - IDLE: wait for `gray_ready`=1.
  - LOAD: at the start of each centre row y, read columns 0 and 1 of rows y-1, y, y+1 (6 reads, column-major, top to bottom).
  - READ: read column x+1 of rows y-1, y, y+1 (3 reads).
  - WRITE: one cycle with `lbp_valid`=1, `lbp_addr`=y*128+x, code computed combinationally from the window. Then shift the window and go to READ (x<126), LOAD (x=126, y<126) or DONE (x=126, y=126).
  - DONE: `finish`=1, `gray_req`=0, `lbp_valid`=0; stay until reset.
- `gray_data` is only sampled in the cycle after a request; it may be high-Z otherwise and must not affect state.

## Timing
- Reset (`reset`=0 at a rising edge): every output goes to 0 (`gray_req`, `gray_addr`, `lbp_valid`, `lbp_addr`, `lbp_data`, `finish`). FSM → IDLE, counters y=1, x=1.
- Reset asserted mid-operation aborts immediately; the next run restarts at pixel (1,1).
- Read handshake:
  - `gray_req`/`gray_addr` are registered outputs, presented at edge k.
  - Memory returns data in the same cycle (driven before the falling edge).
  - DUT captures `gray_data` at edge k+1, while issuing the next address.
  - One read per cycle; `gray_req` stays high across consecutive reads.
- Write: `lbp_valid` is high for exactly one cycle per code; `lbp_addr`/`lbp_data` are stable for the whole cycle. The memory samples on the falling edge.
- Latency:
  - Row start: 6 + 3 reads + 1 write = 10 cycles to the first code of the row.
  - Steady state: 4 cycles per code.
  - Total is roughly 126·(6 + 126·4) cycles after `gray_ready`.
- `finish` rises in the cycle after the final write (addr 126·128+126 = 16254) and stays high.
- `gray_ready` low in IDLE: no requests issued.

## Test plan
- Uniform image, all 0x80 → every interior code 0xFF, all borders 0x00, exactly 15876 `lbp_valid` pulses, then `finish`=1.
- Ramp image, gray(y,x) = x → every interior code 0xD6; borders 0.
- Ramp image, gray(y,x) = y → every interior code 0xF8.
- All-zero image with single 0xFF at (64,64) → code at addr 64·128+64 = 0x00; all other interior codes 0xFF.
- Reset driven low for 2 cycles midway through row 40, then released → outputs 0 during reset; rerun restarts at addr 129 and the final memory equals a clean run; `finish` only after the full pass.
- Hold `gray_ready`=0 for 20 cycles after reset → `gray_req` stays 0 and no writes occur; normal processing follows once `gray_ready`=1.

Source files
------------

// File: rtl/lbp.sv
// Local Binary Pattern engine over a 128x128 8-bit image.
// Streams a 3x3 window from image memory and writes one code per interior pixel.
module lbp (
    input  logic        clk,
    input  logic        reset,
    input  logic        gray_ready,
    output logic        gray_req,
    output logic [13:0] gray_addr,
    input  logic [7:0]  gray_data,
    output logic        lbp_valid,
    output logic [13:0] lbp_addr,
    output logic [7:0]  lbp_data,
    output logic        finish
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t      state;
    logic [6:0]  y;
    logic [6:0]  x;
    logic [2:0]  cnt;
    logic [1:0]  dst_row;
    logic [1:0]  dst_col;
    logic [7:0]  win [0:2][0:2];
    logic [7:0]  code;

    logic [2:0]  ld_next;
    logic [2:0]  ld_tmp;
    logic [1:0]  ld_row;
    logic        ld_col;
    logic [1:0]  rd_row;

    // Row/column of the next LOAD read (column-major, top to bottom)
    always_comb begin
        ld_next = cnt + 3'd1;
        ld_tmp  = ld_next - 3'd3;
        ld_row  = ld_next[1:0];
        ld_col  = 1'b0;
        rd_row  = cnt[1:0] + 2'd1;
        if (ld_next >= 3'd3) begin
            ld_row = ld_tmp[1:0];
            ld_col = 1'b1;
        end
    end

    // Sequencer: issues reads, strobes writes, walks the interior in raster order
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            y         <= 7'd1;
            x         <= 7'd1;
            cnt       <= 3'd0;
            dst_row   <= 2'd0;
            dst_col   <= 2'd0;
            gray_req  <= 1'b0;
            gray_addr <= 14'd0;
            lbp_valid <= 1'b0;
            lbp_addr  <= 14'd0;
            finish    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gray_ready) begin
                        state     <= LOAD;
                        cnt       <= 3'd0;
                        gray_req  <= 1'b1;
                        gray_addr <= {y - 7'd1, 7'd0};
                        dst_row   <= 2'd0;
                        dst_col   <= 2'd0;
                    end
                end
                LOAD: begin
                    if (cnt == 3'd5) begin
                        state     <= READ;
                        cnt       <= 3'd0;
                        gray_addr <= {y - 7'd1, x + 7'd1};
                        dst_row   <= 2'd0;
                        dst_col   <= 2'd2;
                    end else begin
                        cnt       <= ld_next;
                        gray_addr <= {y - 7'd1 + {5'd0, ld_row},
                                      6'd0, ld_col};
                        dst_row   <= ld_row;
                        dst_col   <= {1'b0, ld_col};
                    end
                end
                READ: begin
                    if (cnt == 3'd2) begin
                        state     <= WRITE;
                        gray_req  <= 1'b0;
                        lbp_valid <= 1'b1;
                        lbp_addr  <= {y, x};
                    end else begin
                        cnt       <= cnt + 3'd1;
                        gray_addr <= {y - 7'd1 + {5'd0, rd_row},
                                      x + 7'd1};
                        dst_row   <= rd_row;
                    end
                end
                WRITE: begin
                    lbp_valid <= 1'b0;
                    cnt       <= 3'd0;
                    if (x < 7'd126) begin
                        state     <= READ;
                        x         <= x + 7'd1;
                        gray_req  <= 1'b1;
                        gray_addr <= {y - 7'd1, x + 7'd2};
                        dst_row   <= 2'd0;
                        dst_col   <= 2'd2;
                    end else if (y < 7'd126) begin
                        state     <= LOAD;
                        x         <= 7'd1;
                        y         <= y + 7'd1;
                        gray_req  <= 1'b1;
                        gray_addr <= {y, 7'd0};
                        dst_row   <= 2'd0;
                        dst_col   <= 2'd0;
                    end else begin
                        state  <= DONE;
                        finish <= 1'b1;
                    end
                end
                DONE: begin
                    finish <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Window: capture returned pixel, shift left one column after each write
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= 8'd0;
                end
            end
        end else if (gray_req) begin
            win[dst_row][dst_col] <= gray_data;
        end else if (state == WRITE) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
        end
    end

    // Code: one bit per neighbour that is not below the centre
    always_comb begin
        code    = 8'd0;
        code[0] = win[0][0] >= win[1][1];
        code[1] = win[0][1] >= win[1][1];
        code[2] = win[0][2] >= win[1][1];
        code[3] = win[1][0] >= win[1][1];
        code[4] = win[1][2] >= win[1][1];
        code[5] = win[2][0] >= win[1][1];
        code[6] = win[2][1] >= win[1][1];
        code[7] = win[2][2] >= win[1][1];
    end

    assign lbp_data = lbp_valid ? code : 8'd0;

endmodule

// File: tb/tb_lbp.sv
// Testbench for lbp: image/result memory models and a reference LBP model.
// Partial runs on structured images, then one full run with reset abort.
module tb_lbp;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        gray_ready = 1'b0;
    logic        gray_req;
    logic [13:0] gray_addr;
    logic [7:0]  gray_data;
    logic        lbp_valid;
    logic [13:0] lbp_addr;
    logic [7:0]  lbp_data;
    logic        finish;

    lbp dut (
        .clk        (clk),
        .reset      (reset),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .gray_data  (gray_data),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish)
    );

    always #5 clk = ~clk;

    logic [7:0] img  [16384];
    logic [7:0] res  [16384];
    logic [7:0] expm [16384];

    assign gray_data = gray_req ? img[gray_addr] : 8'hzz;

    int checks = 0;
    int errors = 0;
    int wcount = 0;
    int order_err = 0;
    int early_fin = 0;
    int ny = 1;
    int nx = 1;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Result memory: captures writes and tracks raster order
    always @(negedge clk) begin
        if (!reset) begin
            ny = 1;
            nx = 1;
        end else if (lbp_valid) begin
            if (int'(lbp_addr) != ny * 128 + nx) order_err++;
            res[lbp_addr] = lbp_data;
            wcount++;
            if (nx < 126) nx++;
            else begin
                nx = 1;
                ny++;
            end
        end
        if (finish && wcount < 15876) early_fin++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [7:0] ref_code(input int yy, input int xx);
        int dy [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
        int dx [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
        logic [7:0] c = 8'd0;
        for (int i = 0; i < 8; i++) begin
            if (img[(yy + dy[i]) * 128 + xx + dx[i]] >= img[yy * 128 + xx])
                c = c | 8'(1 << i);
        end
        return c;
    endfunction

    task automatic build_exp(input int rows);
        for (int a = 0; a < 16384; a++) expm[a] = 8'd0;
        for (int yy = 1; yy <= rows; yy++)
            for (int xx = 1; xx <= 126; xx++)
                expm[yy * 128 + xx] = ref_code(yy, xx);
    endtask

    task automatic cmp_mem(input string tag);
        int nbad = 0;
        for (int a = 0; a < 16384; a++)
            if (res[a] !== expm[a]) nbad++;
        check(tag, nbad, 0);
    endtask

    task automatic clear_res();
        for (int a = 0; a < 16384; a++) res[a] = 8'd0;
    endtask

    task automatic hold_reset(input int n, output int bad);
        bad = 0;
        reset = 1'b0;
        repeat (n) begin
            tick();
            if (gray_req || gray_addr != 0 || lbp_valid ||
                lbp_addr != 0 || lbp_data != 0 || finish) bad++;
        end
    endtask

    task automatic run_partial(input string tag, input int rows);
        int guard = 0;
        int bad;
        clear_res();
        hold_reset(2, bad);
        check({tag, "_rst"}, bad, 0);
        gray_ready = 1'b1;
        reset = 1'b1;
        wcount = 0;
        order_err = 0;
        while (wcount < rows * 126 && guard < 4000) begin
            tick();
            guard++;
        end
        check({tag, "_writes"}, wcount, rows * 126);
        hold_reset(2, bad);
        check({tag, "_abort"}, bad, 0);
        check({tag, "_order"}, order_err, 0);
        build_exp(rows);
        cmp_mem({tag, "_mem"});
    endtask

    initial begin
        int bad;
        int lat;
        int guard;

        hold_reset(2, bad);
        check("rst_req", int'(gray_req), 0);
        check("rst_gaddr", int'(gray_addr), 0);
        check("rst_valid", int'(lbp_valid), 0);
        check("rst_laddr", int'(lbp_addr), 0);
        check("rst_ldata", int'(lbp_data), 0);
        check("rst_finish", int'(finish), 0);

        for (int a = 0; a < 16384; a++) img[a] = 8'h80;
        run_partial("uniform", 2);
        check("uniform_spot", int'(res[129]), 8'hFF);

        for (int a = 0; a < 16384; a++) img[a] = 8'(a % 128);
        run_partial("ramp_x", 2);
        check("ramp_x_spot", int'(res[133]), 8'hD6);

        for (int a = 0; a < 16384; a++) img[a] = 8'(a / 128);
        run_partial("ramp_y", 2);
        check("ramp_y_spot", int'(res[261]), 8'hF8);

        for (int a = 0; a < 16384; a++) img[a] = 8'd0;
        img[2 * 128 + 64] = 8'hFF;
        run_partial("spike", 3);
        check("spike_centre", int'(res[2 * 128 + 64]), 8'h00);
        check("spike_nbr", int'(res[1 * 128 + 63]), 8'hFF);

        for (int a = 0; a < 16384; a++) img[a] = 8'($urandom_range(0, 3));
        clear_res();
        gray_ready = 1'b0;
        reset = 1'b1;
        wcount = 0;
        order_err = 0;
        bad = 0;
        repeat (20) begin
            tick();
            if (gray_req || lbp_valid) bad++;
        end
        check("idle_req", bad, 0);
        check("idle_writes", wcount, 0);

        gray_ready = 1'b1;
        lat = 0;
        while (!lbp_valid && lat < 50) begin
            tick();
            lat++;
        end
        check("first_latency", lat, 10);
        check("first_addr", int'(lbp_addr), 129);
        check("first_code", int'(lbp_data), int'(ref_code(1, 1)));

        lat = 0;
        do begin
            tick();
            lat++;
        end while (!lbp_valid && lat < 50);
        check("steady_gap", lat, 4);

        guard = 0;
        while (wcount < 4 * 126 + 63 && guard < 5000) begin
            tick();
            guard++;
        end
        check("pre_abort_writes", wcount, 4 * 126 + 63);
        check("pre_abort_order", order_err, 0);
        hold_reset(2, bad);
        check("midrun_rst_out", bad, 0);

        reset = 1'b1;
        wcount = 0;
        order_err = 0;
        early_fin = 0;
        guard = 0;
        while (!finish && guard < 70000) begin
            tick();
            guard++;
        end
        check("finish", int'(finish), 1);
        check("total_writes", wcount, 15876);
        check("order", order_err, 0);
        check("early_finish", early_fin, 0);

        bad = 0;
        repeat (5) begin
            tick();
            if (!finish || gray_req || lbp_valid) bad++;
        end
        check("done_hold", bad, 0);

        build_exp(126);
        cmp_mem("final_mem");
        check("last_code", int'(res[16254]), int'(ref_code(126, 126)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
